// File: rtl/uop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uop_pkg
// Purpose  : Types and widths shared by the uop cache and the uop fetch unit.
// Revision : 1.0
// ============================================================================
package uop_pkg;

    localparam int UOP_ADDR_W = 9;
    localparam int UOP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/uop_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uop_fetch_fifo
// Purpose  : Small synchronous FIFO with first-word-fall-through head.
// Revision : 1.0
// ============================================================================
module uop_fetch_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uop_fetch.sv
`default_nettype none
// ============================================================================
// Module   : uop_fetch
// Purpose  : Credit-throttled read sequencer between the uop cache and issue.
// Revision : 1.0
// ============================================================================
module uop_fetch
    import uop_pkg::*;
#(
    parameter int ADDR_W     = UOP_ADDR_W,
    parameter int DATA_W     = UOP_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              read_enable,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] cache_data,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [DATA_W-1:0] uop_data
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uop_fetch: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_can_issue;
    logic              w_read_en;
    logic              w_push;
    logic              w_pop;
    logic              w_drained;
    logic [LEN_W-1:0]  w_run_len;

    // Credits count buffered uops plus the one possibly returning; a same-cycle
    // pop is deliberately not credited back.
    assign w_can_issue = (w_count + CNT_W'(r_inflight)) < c_depth;
    assign w_read_en   = (r_state == FETCH) && w_can_issue;
    assign w_push      = r_inflight;
    assign w_pop       = !w_empty && uop_ready;
    assign w_run_len   = (length > c_max_len) ? c_max_len : length;

    // The FIFO will be empty after this edge with nothing left in the cache pipe.
    assign w_drained = !w_push && (w_empty || (w_count == CNT_W'(1) && w_pop));

    assign read_enable  = w_read_en;
    assign read_address = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign uop_valid    = !w_empty;

    uop_fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (cache_data),
        .pop       (w_pop),
        .head      (uop_data),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_read_en;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= start_addr;
                            r_remaining <= w_run_len;
                            r_busy      <= 1'b1;
                            r_state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (w_read_en) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) w_push |-> !w_full);

endmodule
`default_nettype wire

// File: tb/tb_uop_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_uop_fetch
// Purpose  : Self-checking bench for uop_fetch with a behavioural cache model.
// Revision : 1.0
// ============================================================================
module tb_uop_fetch;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          read_enable;
    logic [AW-1:0] read_address;
    logic [DW-1:0] cache_data;
    logic          uop_valid;
    logic          uop_ready;
    logic [DW-1:0] uop_data;

    logic [DW-1:0] mem [512];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [8:0]  addr;
        logic [9:0]  len;
        int          stall;
        int          restart_at;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_first_vld;
        int          exp_done_lat;
    } vec_t;

    typedef struct {
        int          reads;
        int          pops;
        int          errs;
        logic [31:0] first;
        logic [31:0] last;
        int          first_rd;
        int          first_vld;
        int          done_lat;
        int          done_cnt;
        int          stall_reads;
        int          stall_bad;
        int          busy_hi;
    } res_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    // Cache: 1-cycle read latency, no output register.
    always @(posedge clk) begin
        if (read_enable) cache_data <= mem[read_address];
    end

    uop_fetch #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .read_enable  (read_enable),
        .read_address (read_address),
        .cache_data   (cache_data),
        .uop_valid    (uop_valid),
        .uop_ready    (uop_ready),
        .uop_data     (uop_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " read_enable"}, 32'(read_enable), 32'd0);
        check({tag, " read_address"}, 32'(read_address), 32'd0);
        check({tag, " uop_valid"}, 32'(uop_valid), 32'd0);
        check({tag, " uop_data"}, uop_data, 32'd0);
    endtask

    // Expected stream: the uops at start_addr, start_addr+1, ... modulo 512,
    // for min(length, 512) entries.
    task automatic run(input logic [8:0] a, input logic [9:0] n, input int stall,
                       input int restart_at, input bit rnd, output res_t r);
        logic [31:0] q [$];
        logic [8:0]  exp_addr;
        int          nn;
        r = '{default: 0};
        r.done_lat = -1;
        nn = (n > 10'd512) ? 512 : int'(n);
        for (int i = 0; i < nn; i++) q.push_back(32'hC0DE0000 + 32'((int'(a) + i) % 512));
        exp_addr   = a;
        start_addr = a;
        length     = n;
        start      = 1'b1;
        uop_ready  = (stall == 0);
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (rnd) uop_ready = ($urandom_range(0, 3) != 0);
            else     uop_ready = (k > stall);
            if (r.done_lat < 0 && !done && (k == restart_at || (rnd && $urandom_range(0, 7) == 0))) begin
                start      = 1'b1;
                start_addr = a + 9'd100;
                length     = 10'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) r.busy_hi++;
            if (read_enable) begin
                if (r.first_rd == 0) r.first_rd = k;
                if (read_address !== exp_addr) r.errs++;
                exp_addr = exp_addr + 9'd1;
                r.reads++;
                if (k <= stall) r.stall_reads++;
            end
            if (uop_valid) begin
                if (r.first_vld == 0) r.first_vld = k;
                if (k <= stall && uop_data !== 32'hC0DE0000 + 32'(a)) r.stall_bad++;
                if (uop_ready) begin
                    if (r.pops == 0) r.first = uop_data;
                    r.last = uop_data;
                    r.pops++;
                    if (q.size() == 0) r.errs++;
                    else if (q.pop_front() !== uop_data) r.errs++;
                end
            end
            if (done) begin
                r.done_cnt++;
                if (r.done_lat < 0) r.done_lat = k;
            end
            tick();
            if (r.done_lat >= 0 && k >= r.done_lat + 3) break;
        end
        start     = 1'b0;
        r.errs   += q.size();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        res_t r;
        bit   busy_ok;
        run(v.addr, v.len, v.stall, v.restart_at, 1'b0, r);
        check({tag, " reads"}, 32'(r.reads), 32'(v.exp_n));
        check({tag, " pops"}, 32'(r.pops), 32'(v.exp_n));
        check({tag, " order errors"}, 32'(r.errs), 32'd0);
        check({tag, " done count"}, 32'(r.done_cnt), 32'd1);
        check({tag, " first read cycle"}, 32'(r.first_rd), (v.exp_n > 0) ? 32'd1 : 32'd0);
        check({tag, " first valid cycle"}, 32'(r.first_vld), 32'(v.exp_first_vld));
        if (v.exp_n > 0) begin
            check({tag, " first uop"}, r.first, v.exp_first);
            check({tag, " last uop"}, r.last, v.exp_last);
        end
        if (v.exp_done_lat >= 0) check({tag, " done latency"}, 32'(r.done_lat), 32'(v.exp_done_lat));
        if (v.stall > 0) begin
            check({tag, " stalled reads <= 4"}, 32'(r.stall_reads <= 4), 32'd1);
            check({tag, " stalled head stable"}, 32'(r.stall_bad), 32'd0);
        end
        if (v.exp_n == 0) busy_ok = (r.busy_hi == 0);
        else busy_ok = (r.busy_hi >= r.done_lat - 1) && (r.busy_hi <= r.done_lat);
        check({tag, " busy span"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   k;
        int   cnt_done;
        int   cnt_valid;

        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE0000 + 32'(i);

        //               addr  len  stall rst  n    first          last           vld done
        vecs[0] = '{9'd10,  10'd5,   0,  0,   5, 32'hC0DE000A, 32'hC0DE000E, 3,  8};
        vecs[1] = '{9'd510, 10'd4,   0,  0,   4, 32'hC0DE01FE, 32'hC0DE0001, 3,  7};
        vecs[2] = '{9'd0,   10'd0,   0,  0,   0, 32'h0,        32'h0,        0,  1};
        vecs[3] = '{9'd100, 10'd8,  10,  0,   8, 32'hC0DE0064, 32'hC0DE006B, 3, -1};
        vecs[4] = '{9'd50,  10'd6,   0,  2,   6, 32'hC0DE0032, 32'hC0DE0037, 3,  9};
        vecs[5] = '{9'd3,   10'd512, 0,  0, 512, 32'hC0DE0003, 32'hC0DE0002, 3, 515};
        vecs[6] = '{9'd7,   10'd700, 0,  0, 512, 32'hC0DE0007, 32'hC0DE0006, 3, 515};
        vecs[7] = '{9'd511, 10'd1,   0,  0,   1, 32'hC0DE01FF, 32'hC0DE01FF, 3,  4};

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        uop_ready  = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Reset two cycles after the first valid uop aborts the run outright.
        start_addr = 9'd20;
        length     = 10'd6;
        uop_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!uop_valid && k < 20) begin
            tick();
            k++;
        end
        check("abort first valid seen", 32'(uop_valid), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("abort");
        reset     = 1'b0;
        cnt_done  = 0;
        cnt_valid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) cnt_done++;
            if (uop_valid) cnt_valid++;
        end
        check("abort no done", 32'(cnt_done), 32'd0);
        check("abort no stale uop", 32'(cnt_valid), 32'd0);
        apply_vec('{9'd0, 10'd2, 0, 0, 2, 32'hC0DE0000, 32'hC0DE0001, 3, 5}, "post-abort");
        tick();

        // Random runs, random backpressure and ignored start pulses mid-run.
        for (int t = 0; t < 20; t++) begin
            logic [8:0] a;
            logic [9:0] n;
            a = 9'($urandom_range(0, 511));
            n = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
            run(a, n, 0, 0, 1'b1, r);
            check($sformatf("rnd%0d errors", t), 32'(r.errs), 32'd0);
            check($sformatf("rnd%0d pops", t), 32'(r.pops), 32'(n));
            check($sformatf("rnd%0d reads", t), 32'(r.reads), 32'(n));
            check($sformatf("rnd%0d done count", t), 32'(r.done_cnt), 32'd1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uop_fetch.md
Name: uop_fetch

Overview:
- Sequencer directly downstream of the uop cache (512 x 32 BRAM in SDP mode, 1-cycle read latency, no output register).
- On a start command it issues a run of consecutive reads to the cache and absorbs the 1-cycle latency.
- It buffers returned uops in a small FIFO and presents them on a valid/ready stream to the issue/execute stage.
- Read issue is credit-throttled, so no uop is ever lost under backpressure.

Parameters:
- ADDR_W, 9, uop cache address width (512 entries).
- DATA_W, 32, uop width.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2 and >= 2. A value of >= 3 sustains 1 uop/cycle.

Ports:
- clk  in  1  single clock, also drives the cache.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- start_addr  in  ADDR_W  first cache address of the run.
- length  in  ADDR_W+1  number of uops, 0..512.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run is fully delivered.
- read_enable  out  1  to the cache read enable.
- read_address  out  ADDR_W  to the cache read address.
- cache_data  in  DATA_W  from cache out_instruction; valid the cycle after read_enable.
- uop_valid  out  1  output stream valid.
- uop_ready  in  1  output stream ready from the consumer.
- uop_data  out  DATA_W  output uop; equals the FIFO head.

Behaviour:
- Reset:
  - All outputs are 0: busy, done, read_enable, read_address, uop_valid, uop_data.
  - State is IDLE; the FIFO and the in-flight flag are cleared.
  - Reset mid-run aborts the run immediately: no done pulse, and cache data returning in the next cycle is discarded.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE, start=1, length>0: latch addr=start_addr and remaining=length; go to FETCH; busy=1 next cycle.
  - IDLE, start=1, length=0: no reads issued; done=1 in the next cycle; stay IDLE; busy stays 0.
  - FETCH: issue a read when can_issue, i.e. (fifo_count + inflight) < FIFO_DEPTH.
    - On issue: addr increments modulo 2^ADDR_W, so 511 wraps to 0. remaining decrements.
    - When the last read issues, go to DRAIN.
  - DRAIN: when inflight=0, FIFO empty and no push this cycle, assert done for one cycle and return to IDLE with busy=0.
  - A start pulse arriving in FETCH or DRAIN has no effect.
- Read issue rules:
  - read_enable and read_address are combinational from state and registers.
  - read_enable is high only in FETCH && can_issue; it is never high in IDLE or DRAIN.
  - The conservative credit rule ignores a same-cycle pop.
- Return path:
  - inflight <= read_enable, registered each cycle.
  - When inflight=1, cache_data is pushed into the FIFO at the end of that cycle.
  - Credits guarantee the FIFO is never full on a push; an assertion checks this.
- Latency:
  - start is sampled at edge S.
  - First read_enable is in cycle S+1; data is on cache_data in S+2 and pushed at the end of S+2.
  - uop_valid is first high in cycle S+3.
- Output stream:
  - uop_valid = FIFO not empty; uop_data = FIFO head.
  - Pop on uop_valid && uop_ready.
  - uop_data holds stable while uop_valid=1 and uop_ready=0.
  - A simultaneous push and pop with a full FIFO is legal; count is unchanged.
- Ordering: uops leave in strictly ascending address order, modulo wrap.
- Throughput: 1 uop/cycle with uop_ready held high and FIFO_DEPTH >= 3.
- Run length:
  - length=512 reads every entry exactly once, starting at start_addr.
  - Any length above 512 is clamped to 512.

Decomposition:
- Shared package uop_pkg holds:
  - UOP_ADDR_W=9 and UOP_DATA_W=32, shared with the uop cache;
  - the fetch state typedef {IDLE, FETCH, DRAIN}.
- Sub-module uop_fetch_fifo: a synchronous FIFO with push, pop, count, empty and full outputs, and first-word-fall-through head.
- The top level holds the FSM, address and remaining counters, the inflight flag and the credit logic.

Test Plan:
- Cache preloaded with mem[i]=0xC0DE0000+i; start_addr=10, length=5, uop_ready=1:
  - read_enable is high in cycles S+1..S+5 at addresses 10..14;
  - uop_data is 0xC0DE000A..0xC0DE000E in cycles S+3..S+7;
  - done pulses in cycle S+8.
- Wrap: start_addr=510, length=4 -> addresses 510, 511, 0, 1; data order matches; done once.
- Backpressure: length=8 with uop_ready=0 for 10 cycles, then 1:
  - read_enable is issued at most 4 times while stalled;
  - uop_data stays 0xC0DE0000+start_addr while stalled;
  - all 8 uops are delivered in order with none lost or duplicated.
- length=0 -> zero reads, busy stays 0, done pulses in cycle S+1.
- start re-asserted during FETCH with a different addr -> ignored; the original run completes unchanged.
- Reset asserted 2 cycles after the first uop_valid -> next cycle all outputs are 0 with no done pulse; a new run (start_addr=0, length=2) then behaves exactly as from power-on.
